// File: rtl/conv_window_gen_3x3.sv
// Purpose: streaming 3x3 sliding-window generator (valid mode, stride 1) fed by raster-order pixels.
// Latency: 1 cycle from accepted pixel to window/window_valid/frame_done update.
// Backpressure: none; every pixel with data_in_valid=1 is accepted, idle cycles hold all state.
module conv_window_gen_3x3 #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    data_in_valid,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [9*DATA_WIDTH-1:0] window,
  output logic                    window_valid,
  output logic                    frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  // lb0 holds the previous row, lb1 the row before that, both indexed by column.
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  // win[3*r+c]: r=0 oldest row, c=0 oldest column.
  logic [DATA_WIDTH-1:0] win [9];
  logic [DATA_WIDTH-1:0] lb0_rd;
  logic [DATA_WIDTH-1:0] lb1_rd;
  logic                  in_window_area;
  logic                  last_pixel;

  assign lb0_rd         = lb0[col];
  assign lb1_rd         = lb1[col];
  assign in_window_area = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign last_pixel     = (row == ROW_LAST) && (col == COL_LAST);

  // Raster position of the next accepted pixel; wraps at end of row and end of frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (data_in_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row == ROW_LAST) begin
          row <= '0;
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Line buffers age by one row per write; no reset needed since row>=2 gating hides stale data.
  always_ff @(posedge clk) begin
    if (data_in_valid) begin
      lb1[col] <= lb0_rd;
      lb0[col] <= data_in;
    end
  end

  // Window shifts left one column per pixel; the new right column comes from the line buffers and input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        win[i] <= '0;
      end
    end else if (data_in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[3*r]   <= win[3*r+1];
        win[3*r+1] <= win[3*r+2];
      end
      win[2] <= lb1_rd;
      win[5] <= lb0_rd;
      win[8] <= data_in;
    end
  end

  // Strobes registered alongside the window so they line up with its contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= data_in_valid && in_window_area;
      frame_done   <= data_in_valid && last_pixel;
    end
  end

  // Flatten the window registers onto the output bus.
  always_comb begin
    window = '0;
    for (int i = 0; i < 9; i++) begin
      window[DATA_WIDTH*i +: DATA_WIDTH] = win[i];
    end
  end

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Purpose: self-checking bench for conv_window_gen_3x3 using a 4x4 and a default 28x28 instance.
// Latency: expects outputs one cycle after each accepted pixel.
// Backpressure: none to model; stimulus inserts idle cycles only.
module tb_conv_window_gen_3x3;

  logic         clk = 1'b0;
  logic         reset;
  logic         v4, v28;
  logic [15:0]  d4, d28;
  logic [143:0] w4, w28;
  logic         wv4, wv28, fd4, fd28;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_window_gen_3x3 #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .reset(reset), .data_in_valid(v4), .data_in(d4),
    .window(w4), .window_valid(wv4), .frame_done(fd4)
  );

  conv_window_gen_3x3 #(.DATA_WIDTH(16), .IMG_WIDTH(28), .IMG_HEIGHT(28)) dut28 (
    .clk(clk), .reset(reset), .data_in_valid(v28), .data_in(d28),
    .window(w28), .window_valid(wv28), .frame_done(fd28)
  );

  typedef struct packed {
    logic         vld;
    logic [15:0]  dat;
    logic         exp_vld;
    logic         exp_fd;
    logic         chk_win;
    logic [143:0] exp_win;
  } vec_t;

  vec_t tbl [19];

  int           cap_idx [$];
  logic [143:0] cap_win [$];
  int           fd_idx  [$];
  int           idle_viol;

  task automatic chk_int(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_win(string name, logic [143:0] act, logic [143:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [143:0] pack9(int off, int a0, int a1, int a2, int a3, int a4,
                                         int a5, int a6, int a7, int a8);
    logic [143:0] w;
    w[16*0 +: 16] = 16'(off + a0);
    w[16*1 +: 16] = 16'(off + a1);
    w[16*2 +: 16] = 16'(off + a2);
    w[16*3 +: 16] = 16'(off + a3);
    w[16*4 +: 16] = 16'(off + a4);
    w[16*5 +: 16] = 16'(off + a5);
    w[16*6 +: 16] = 16'(off + a6);
    w[16*7 +: 16] = 16'(off + a7);
    w[16*8 +: 16] = 16'(off + a8);
    return w;
  endfunction

  // Hand-computed windows of the 4x4 frame with pixel = 16*row+col, plus an offset.
  function automatic logic [143:0] exp_w4(int i, int off);
    case (i)
      0:       return pack9(off, 0, 1, 2, 16, 17, 18, 32, 33, 34);
      1:       return pack9(off, 1, 2, 3, 17, 18, 19, 33, 34, 35);
      2:       return pack9(off, 16, 17, 18, 32, 33, 34, 48, 49, 50);
      default: return pack9(off, 17, 18, 19, 33, 34, 35, 49, 50, 51);
    endcase
  endfunction

  function automatic vec_t mk(logic vld, int dat, logic ev, logic efd, logic cw, logic [143:0] ew);
    vec_t t;
    t.vld = vld; t.dat = 16'(dat); t.exp_vld = ev; t.exp_fd = efd; t.chk_win = cw; t.exp_win = ew;
    return t;
  endfunction

  // Feed npix pixels of a 4x4 frame (value off+16*row+col), optionally with random idle cycles.
  task automatic run4(int off, bit gaps, int npix);
    int n;
    cap_idx.delete();
    cap_win.delete();
    fd_idx.delete();
    idle_viol = 0;
    for (int p = 0; p < npix; p++) begin
      if (gaps) begin
        n = $urandom_range(2, 0);
        for (int k = 0; k < n; k++) begin
          @(negedge clk);
          v4 = 1'b0;
          @(posedge clk);
          #1;
          if (wv4 || fd4) idle_viol++;
        end
      end
      @(negedge clk);
      v4 = 1'b1;
      d4 = 16'(off + 16 * (p / 4) + p % 4);
      @(posedge clk);
      #1;
      if (wv4) begin
        cap_idx.push_back(p);
        cap_win.push_back(w4);
      end
      if (fd4) fd_idx.push_back(p);
    end
  endtask

  task automatic check4(string tag, int off);
    int exp_idx [4] = '{10, 11, 14, 15};
    chk_int($sformatf("%s_nwin", tag), cap_idx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_idx.size()) begin
        chk_int($sformatf("%s_idx%0d", tag, i), cap_idx[i], exp_idx[i]);
        chk_win($sformatf("%s_win%0d", tag, i), cap_win[i], exp_w4(i, off));
      end
    end
    chk_int($sformatf("%s_nfd", tag), fd_idx.size(), 1);
    if (fd_idx.size() > 0) chk_int($sformatf("%s_fd_at", tag), fd_idx[0], 15);
  endtask

  initial begin
    int nwin, nfd, fd_at, patt_bad;
    logic [143:0] last28;

    // Continuous 4x4 frame, one idle inserted after the first window and one at the end.
    tbl[0]  = mk(1, 0,  0, 0, 0, '0);
    tbl[1]  = mk(1, 1,  0, 0, 0, '0);
    tbl[2]  = mk(1, 2,  0, 0, 0, '0);
    tbl[3]  = mk(1, 3,  0, 0, 0, '0);
    tbl[4]  = mk(1, 16, 0, 0, 0, '0);
    tbl[5]  = mk(1, 17, 0, 0, 0, '0);
    tbl[6]  = mk(1, 18, 0, 0, 0, '0);
    tbl[7]  = mk(1, 19, 0, 0, 0, '0);
    tbl[8]  = mk(1, 32, 0, 0, 0, '0);
    tbl[9]  = mk(1, 33, 0, 0, 0, '0);
    tbl[10] = mk(1, 34, 1, 0, 1, pack9(0, 0, 1, 2, 16, 17, 18, 32, 33, 34));
    tbl[11] = mk(0, 0,  0, 0, 1, pack9(0, 0, 1, 2, 16, 17, 18, 32, 33, 34));
    tbl[12] = mk(1, 35, 1, 0, 1, pack9(0, 1, 2, 3, 17, 18, 19, 33, 34, 35));
    tbl[13] = mk(1, 48, 0, 0, 0, '0);
    tbl[14] = mk(1, 49, 0, 0, 0, '0);
    tbl[15] = mk(1, 50, 1, 0, 1, pack9(0, 16, 17, 18, 32, 33, 34, 48, 49, 50));
    tbl[16] = mk(1, 51, 1, 1, 1, pack9(0, 17, 18, 19, 33, 34, 35, 49, 50, 51));
    tbl[17] = mk(0, 0,  0, 0, 1, pack9(0, 17, 18, 19, 33, 34, 35, 49, 50, 51));
    tbl[18] = mk(0, 0,  0, 0, 0, '0);

    reset = 1'b1;
    v4 = 1'b0; d4 = '0;
    v28 = 1'b0; d28 = '0;

    // Outputs cleared during reset and in the first cycle after release.
    #12;
    chk_win("rst_win", w4, '0);
    chk_int("rst_vld", int'(wv4), 0);
    chk_int("rst_fd", int'(fd4), 0);
    chk_int("rst_vld28", int'(wv28), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_win("post_rst_win", w4, '0);
    chk_int("post_rst_vld", int'(wv4), 0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      v4 = tbl[i].vld;
      d4 = tbl[i].dat;
      @(posedge clk);
      #1;
      chk_int($sformatf("tbl%0d_vld", i), int'(wv4), int'(tbl[i].exp_vld));
      chk_int($sformatf("tbl%0d_fd", i), int'(fd4), int'(tbl[i].exp_fd));
      if (tbl[i].chk_win) chk_win($sformatf("tbl%0d_win", i), w4, tbl[i].exp_win);
    end

    // Same frame with random idle gaps.
    run4(0, 1'b1, 16);
    check4("gap", 0);
    chk_int("gap_idle_viol", idle_viol, 0);

    // Back-to-back frames with no idle between them.
    run4(0, 1'b0, 16);
    check4("b2b_f1", 0);
    run4(100, 1'b0, 16);
    check4("b2b_f2", 100);

    // Reset after pixel (2,3), then a fresh frame with distinct values.
    run4(0, 1'b0, 12);
    chk_int("pre_reset_vld", int'(wv4), 1);
    #2;
    reset = 1'b1;
    v4 = 1'b0;
    #1;
    chk_int("midrst_vld", int'(wv4), 0);
    chk_int("midrst_fd", int'(fd4), 0);
    chk_win("midrst_win", w4, '0);
    @(negedge clk);
    reset = 1'b0;
    run4(200, 1'b0, 16);
    check4("after_rst", 200);
    @(negedge clk);
    v4 = 1'b0;

    // Default 28x28 frame.
    nwin = 0; nfd = 0; fd_at = -1; patt_bad = 0; last28 = '0;
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        @(negedge clk);
        v28 = 1'b1;
        d28 = 16'(r * 28 + c);
        @(posedge clk);
        #1;
        if (wv28 !== ((r >= 2) && (c >= 2))) patt_bad++;
        if (wv28) nwin++;
        if (fd28) begin
          nfd++;
          fd_at = wv28 ? nwin : -1;
        end
        last28 = w28;
      end
    end
    @(negedge clk);
    v28 = 1'b0;
    @(posedge clk);
    #1;
    chk_int("f28_nwin", nwin, 676);
    chk_int("f28_nfd", nfd, 1);
    chk_int("f28_fd_at", fd_at, 676);
    chk_int("f28_pattern_bad", patt_bad, 0);
    chk_win("f28_last_win", last28, pack9(0, 725, 726, 727, 753, 754, 755, 781, 782, 783));
    chk_int("f28_idle_vld", int'(wv28), 0);
    chk_win("f28_idle_hold", w28, last28);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_window_gen_3x3.md
# conv_window_gen_3x3

Streaming 3x3 sliding-window generator for the convolution layer front end. Accepts one feature-map pixel per cycle in raster order, keeps the two previous rows in line buffers, and presents a full 3x3 window plus a 1-bit `window_valid` strobe to the MAC array. `window_valid` is the signal the downstream 7-cycle 1-bit delay line re-times to align with the pipelined multiply-accumulate result. Valid-mode convolution only: no padding, stride 1.

## Interface
- `DATA_WIDTH`, 16, pixel width in bits.
- `IMG_WIDTH`, 28, pixels per row; must be at least 3.
- `IMG_HEIGHT`, 28, rows per frame; must be at least 3.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data_in_valid`  input  1  `data_in` carries a pixel this cycle. No backpressure: every valid pixel is accepted.
- `data_in`  input  DATA_WIDTH  pixel value.
- `window`  output  9*DATA_WIDTH  3x3 window; element (r,c) is at `[DATA_WIDTH*(3*r+c) +: DATA_WIDTH]`.
  - r=0 is the oldest (top) row; c=0 is the oldest (left) column.
- `window_valid`  output  1  `window` holds a complete, in-frame window this cycle.
- `frame_done`  output  1  one-cycle pulse coinciding with the last `window_valid` of a frame.

## Operation
- **Counters.** `col` counts 0..IMG_WIDTH-1 and `row` counts 0..IMG_HEIGHT-1.
  - Both advance only on an accepted pixel.
  - `col` wraps to 0 and increments `row`.
  - After pixel (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and the next pixel starts a new frame. There is no idle gap requirement.
- **Line buffers.** `lb0` and `lb1`, each IMG_WIDTH entries of DATA_WIDTH, indexed by `col`, read combinationally.
  - On each accepted pixel: `lb1[col] <= lb0[col]` and `lb0[col] <= data_in`.
  - `lb0[col]` therefore holds row-1 and `lb1[col]` holds row-2 at the same column.
- **Window registers.** On each accepted pixel, every window row shifts left: c0<=c1, c1<=c2. The new c2 entries are:
  - r0 gets `lb1[col]` (pre-write value);
  - r1 gets `lb0[col]` (pre-write value);
  - r2 gets `data_in`.
- **window_valid.** Registered: next value = `data_in_valid && row>=2 && col>=2`, using the counters of the accepted pixel.
  - When high, `window` = pixels rows row-2..row, cols col-2..col of that pixel.
  - Windows never straddle a row boundary: the col<2 gating guarantees this.
- **frame_done.** Registered: next value = `data_in_valid && row==IMG_HEIGHT-1 && col==IMG_WIDTH-1`.
- **Window count.** Exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.
- **Idle cycles.** When `data_in_valid`=0, counters, line buffers and `window` hold, and `window_valid`/`frame_done` are 0 the next cycle. Gaps may occur anywhere, including mid-row.
- **Reset (asynchronous, any time, including mid-frame).**
  - `row`, `col`, `window`, `window_valid`, `frame_done` are cleared to 0.
  - Line buffer contents need not be cleared; stale data is never exposed because of the row>=2 gating.
  - The first pixel after reset is treated as pixel (0,0).
- **Arithmetic.** No arithmetic on pixel data; values pass through bit-exact. Counter width is $clog2 of the respective dimension.

## Timing
- **Latency.** 1 cycle from accepted pixel to the `window`/`window_valid` update.
- **Throughput.** One window per cycle in steady state within a row.
  - Each row yields IMG_WIDTH-2 consecutive windows, then 2 invalid cycles while the first two columns of the next row load.
- **Reset values.** All outputs are 0 while `reset` is high and in the first cycle after its release.
- **Downstream use.** The consumer delays `window_valid` by the MAC pipeline depth of 7 cycles; this block does not compensate for it.

## Test plan
- **Single frame, 4x4 image**, pixel = 16*row+col, continuous valid.
  - The first `window_valid` comes 1 cycle after pixel (2,2), i.e. the 11th pixel, with `window` = {0,1,2,16,17,18,32,33,34}.
  - Exactly 4 windows occur in the frame; the last is {17,18,19,33,34,35,49,50,51} with `frame_done`=1.
- **Random valid gaps (~50% duty) on the same 4x4 frame.** The window sequence and values are identical to the continuous case, and `window_valid` is never high on a cycle following an idle input cycle.
- **Back-to-back frames, 4x4, second frame values +100.**
  - Frame 2's first window is {100,101,102,116,117,118,132,133,134}.
  - No window mixes data from the two frames.
- **Reset asserted mid-frame after pixel (2,3), then a fresh frame.**
  - Outputs are 0 immediately.
  - The new frame's first window appears only after its 11th pixel, with correct values and no stale data.
- **Default 28x28 frame.**
  - Exactly 676 `window_valid` pulses.
  - `frame_done` fires exactly once, on the same cycle as the 676th pulse.
  - Each row produces 26 consecutive windows followed by 2 gap cycles.
